fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 148 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - FIFO-fed UART transmitter with start/data/stop framing
module fifo_uart_tx #(
   parameter int DATA_SIZE    = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 tx_en,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_rd_data,
   output logic                 rd_from_fifo,
   output logic                 tx,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic [15:0]          frame_count
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);
   localparam logic              ONE_STOP  = (STOP_BITS == 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t               state_q, state_d;
   logic [BAUD_W-1:0]    baud_q, baud_d;
   logic [BIT_W-1:0]     bit_q, bit_d;
   logic                 stop_q, stop_d;
   logic [DATA_SIZE-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic [15:0]          frame_q, frame_d;

   logic bit_end;
   logic frame_end;
   logic start_ok;

   // Frame boundaries and the start condition are pure decodes of registered state
   assign bit_end   = (baud_q == BAUD_LAST);
   assign frame_end = (state_q == STOP) && bit_end && (ONE_STOP || stop_q);
   assign start_ok  = RESET_N && tx_en && !fifo_empty &&
                      ((state_q == IDLE) || frame_end);

   assign rd_from_fifo = start_ok;
   assign tx           = tx_q;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done      = frame_end;
   assign frame_count  = frame_q;

   // Next-state logic: walk start bit, LSB-first data bits, then stop bit(s)
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      frame_d = frame_q;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (start_ok) begin
               shift_d = fifo_rd_data;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  tx_d    = 1'b1;
                  stop_d  = 1'b0;
                  state_d = STOP;
               end else begin
                  bit_d   = bit_q + BIT_W'(1);
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               baud_d = '0;
               if (frame_end) begin
                  frame_d = frame_q + 16'd1;
                  // A waiting word starts its start bit with no idle gap
                  if (start_ok) begin
                     shift_d = fifo_rd_data;
                     bit_d   = '0;
                     tx_d    = 1'b0;
                     state_d = START;
                  end else begin
                     tx_d    = 1'b1;
                     state_d = IDLE;
                  end
               end else begin
                  stop_d = 1'b1;
               end
            end else begin
               baud_d = baud_q + BAUD_W'(1);
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset abandons any frame in flight
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         frame_q <= 16'd0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         frame_q <= frame_d;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx (one and two stop bits)
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk;
   logic       rst_n [2];
   logic       en    [2];
   logic       empty [2];
   logic [7:0] data  [2];
   logic       rd    [2];
   logic       txl   [2];
   logic       busy  [2];
   logic       done  [2];
   logic [15:0] fc   [2];

   logic       s_tx [2], s_rd [2], s_busy [2], s_done [2];
   logic [15:0] s_fc [2];

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   bit         m_busy [2];
   bit         m_known [2];
   bit         m_rd [2];
   bit         m_done [2];
   int         m_t [2];
   int         m_cnt [2];
   logic [7:0] m_w [2];
   logic [7:0] m_dnow [2];

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         dut;
      logic [7:0] data;
      int         nbits;
      logic [10:0] bits;
   } vec_t;
   vec_t tbl [5];

   fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
      .CLK(clk), .RESET_N(rst_n[0]), .tx_en(en[0]), .fifo_empty(empty[0]),
      .fifo_rd_data(data[0]), .rd_from_fifo(rd[0]), .tx(txl[0]),
      .tx_busy(busy[0]), .tx_done(done[0]), .frame_count(fc[0]));

   fifo_uart_tx #(.DATA_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
      .CLK(clk), .RESET_N(rst_n[1]), .tx_en(en[1]), .fifo_empty(empty[1]),
      .fifo_rd_data(data[1]), .rd_from_fifo(rd[1]), .tx(txl[1]),
      .tx_busy(busy[1]), .tx_done(done[1]), .frame_count(fc[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int frame_len(input int i);
      return (1 + 8 + (i + 1)) * CPB;
   endfunction

   // Line level at frame time t: start bit, eight data bits LSB first, then stop
   function automatic logic exp_tx(input int i);
      int k;
      k = m_t[i] / CPB;
      if (!m_busy[i]) return 1'b1;
      if (k == 0) return 1'b0;
      if (k <= 8) return m_w[i][k-1];
      return 1'b1;
   endfunction

   task automatic model_check(input int i);
      m_done[i] = m_busy[i] && (m_t[i] == frame_len(i) - 1);
      m_rd[i]   = rst_n[i] && en[i] && !empty[i] && (!m_busy[i] || m_done[i]);
      m_dnow[i] = data[i];
      check($sformatf("model_rd%0d", i), 32'(s_rd[i]), 32'(m_rd[i]));
      if (m_known[i]) begin
         check($sformatf("model_tx%0d", i), 32'(s_tx[i]), 32'(exp_tx(i)));
         check($sformatf("model_busy%0d", i), 32'(s_busy[i]), 32'(m_busy[i]));
         check($sformatf("model_done%0d", i), 32'(s_done[i]), 32'(m_done[i]));
         check($sformatf("model_cnt%0d", i), 32'(s_fc[i]), 32'(m_cnt[i] & 16'hFFFF));
      end
   endtask

   task automatic model_update(input int i);
      if (!rst_n[i]) begin
         m_busy[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_known[i] = 1;
      end else if (m_busy[i]) begin
         if (m_done[i]) begin
            m_cnt[i]++;
            if (m_rd[i]) begin m_t[i] = 0; m_w[i] = m_dnow[i]; end
            else m_busy[i] = 0;
         end else begin
            m_t[i]++;
         end
      end else if (m_rd[i]) begin
         m_busy[i] = 1; m_t[i] = 0; m_w[i] = m_dnow[i];
      end
   endtask

   // One clock: present FIFO heads, sample and check at negedge, advance at posedge
   task automatic step();
      empty[0] = (q0.size() == 0);
      data[0]  = empty[0] ? 8'($urandom) : q0[0];
      empty[1] = (q1.size() == 0);
      data[1]  = empty[1] ? 8'($urandom) : q1[0];
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         s_tx[i] = txl[i]; s_rd[i] = rd[i]; s_busy[i] = busy[i];
         s_done[i] = done[i]; s_fc[i] = fc[i];
         model_check(i);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) model_update(i);
      if (m_rd[0] && q0.size() > 0) void'(q0.pop_front());
      if (m_rd[1] && q1.size() > 0) void'(q1.pop_front());
   endtask

   task automatic rst_all();
      q0.delete(); q1.delete();
      en[0] = 0; en[1] = 0;
      rst_n[0] = 0; rst_n[1] = 0;
      step();
      rst_n[0] = 1; rst_n[1] = 1;
   endtask

   int pops, dones, pos, mism, run, maxrun, busyc, bad_tx, bad_busy;

   initial begin
      tbl[0] = '{dut: 0, data: 8'hA5, nbits: 10, bits: 11'b01101001010};
      tbl[1] = '{dut: 0, data: 8'h00, nbits: 10, bits: 11'b01000000000};
      tbl[2] = '{dut: 0, data: 8'hFF, nbits: 10, bits: 11'b01111111110};
      tbl[3] = '{dut: 1, data: 8'h81, nbits: 11, bits: 11'b11100000010};
      tbl[4] = '{dut: 1, data: 8'h55, nbits: 11, bits: 11'b11010101010};

      for (int i = 0; i < 2; i++) begin
         rst_n[i] = 0; en[i] = 0; empty[i] = 1; data[i] = '0;
         m_busy[i] = 0; m_known[i] = 0; m_t[i] = 0; m_cnt[i] = 0; m_w[i] = '0;
      end

      // Reset state
      rst_all();
      step();
      for (int i = 0; i < 2; i++) begin
         check("rst_tx", 32'(s_tx[i]), 32'd1);
         check("rst_busy", 32'(s_busy[i]), 32'd0);
         check("rst_done", 32'(s_done[i]), 32'd0);
         check("rst_cnt", 32'(s_fc[i]), 32'd0);
         check("rst_rd", 32'(s_rd[i]), 32'd0);
      end

      // Table: single frames, exact waveform per bit
      for (int e = 0; e < 5; e++) begin
         vec_t v;
         int d;
         v = tbl[e];
         d = v.dut;
         rst_all();
         if (d == 0) q0.push_back(v.data); else q1.push_back(v.data);
         en[d] = 1;
         pops = 0; dones = 0; pos = -1; mism = 0;
         for (int c = 0; c < v.nbits * CPB + 8; c++) begin
            step();
            if (pos >= 0 && pos < v.nbits * CPB) begin
               if (s_tx[d] !== v.bits[pos / CPB]) mism++;
               pos++;
            end
            if (s_rd[d]) begin pops++; pos = 0; end
            if (s_done[d]) dones++;
         end
         check($sformatf("tbl%0d_wave", e), 32'(mism), 32'd0);
         check($sformatf("tbl%0d_pops", e), 32'(pops), 32'd1);
         check($sformatf("tbl%0d_done", e), 32'(dones), 32'd1);
         check($sformatf("tbl%0d_cnt", e), 32'(s_fc[d]), 32'd1);
         check($sformatf("tbl%0d_idle", e), 32'(s_busy[d]), 32'd0);
      end

      // Back-to-back frames with no idle gap
      rst_all();
      q0.push_back(8'h00); q0.push_back(8'hFF);
      en[0] = 1;
      pops = 0; run = 0; maxrun = 0; busyc = 0;
      for (int c = 0; c < 100; c++) begin
         step();
         if (s_rd[0]) pops++;
         if (s_busy[0]) begin busyc++; run++; if (run > maxrun) maxrun = run; end
         else run = 0;
      end
      check("b2b_pops", 32'(pops), 32'd2);
      check("b2b_busy", 32'(busyc), 32'd80);
      check("b2b_contig", 32'(maxrun), 32'd80);
      check("b2b_cnt", 32'(s_fc[0]), 32'd2);

      // Empty FIFO, then data present but transmit gated off
      rst_all();
      en[0] = 1;
      pops = 0; bad_tx = 0; bad_busy = 0;
      for (int c = 0; c < 200; c++) begin
         if (c == 100) begin en[0] = 0; q0.push_back(8'h3C); end
         step();
         if (s_rd[0]) pops++;
         if (s_tx[0] !== 1'b1) bad_tx++;
         if (s_busy[0] !== 1'b0) bad_busy++;
      end
      check("gate_pops", 32'(pops), 32'd0);
      check("gate_tx", 32'(bad_tx), 32'd0);
      check("gate_busy", 32'(bad_busy), 32'd0);

      // tx_en dropped mid-frame: current frame finishes, next word stays queued
      rst_all();
      q0.push_back(8'hA5); q0.push_back(8'h3C);
      en[0] = 1;
      pops = 0; dones = 0; pos = -1;
      for (int c = 0; c < 70; c++) begin
         step();
         if (pos >= 0) pos++;
         if (s_rd[0]) begin pops++; pos = 0; end
         if (s_done[0]) dones++;
         if (pos == 10) en[0] = 0;
      end
      check("txen_pops", 32'(pops), 32'd1);
      check("txen_done", 32'(dones), 32'd1);
      check("txen_idle", 32'(s_busy[0]), 32'd0);
      check("txen_q", 32'(q0.size()), 32'd1);

      // Reset mid-frame aborts it without counting
      rst_all();
      q0.push_back(8'h55);
      en[0] = 1;
      pos = -1; pops = 0;
      for (int c = 0; c < 40 && pos < 20; c++) begin
         step();
         if (pos >= 0) pos++;
         if (s_rd[0]) begin pops++; pos = 0; end
      end
      check("abort_reach", 32'(pos), 32'd20);
      rst_n[0] = 0;
      step();
      rst_n[0] = 1;
      step();
      check("abort_tx", 32'(s_tx[0]), 32'd1);
      check("abort_busy", 32'(s_busy[0]), 32'd0);
      check("abort_cnt", 32'(s_fc[0]), 32'd0);
      dones = 0;
      for (int c = 0; c < 60; c++) begin
         step();
         if (s_done[0]) dones++;
         if (s_rd[0]) pops++;
      end
      check("abort_done", 32'(dones), 32'd0);
      check("abort_pops", 32'(pops), 32'd1);

      // Randomized traffic on both instances against the frame-time model
      rst_all();
      for (int c = 0; c < 6000; c++) begin
         if ($urandom_range(0, 3) == 0 && q0.size() < 4) q0.push_back(8'($urandom));
         if ($urandom_range(0, 3) == 0 && q1.size() < 4) q1.push_back(8'($urandom));
         for (int i = 0; i < 2; i++) begin
            en[i]    = ($urandom_range(0, 7) != 0);
            rst_n[i] = ($urandom_range(0, 499) != 0);
         end
         step();
      end
      rst_n[0] = 1; rst_n[1] = 1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
